// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, base-ISA opcodes and immediate formats.
package cpu_pkg;

   localparam int DEFAULT_XLEN   = 32;
   localparam int DEFAULT_REG_AW = 5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_t;

   // Register-register ops and unknown opcodes carry no immediate.
   function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
      imm_type_t t;
      case (opcode)
         OP_LOAD, OP_JALR, OP_IMM: t = IMM_I;
         OP_STORE:                 t = IMM_S;
         OP_BRANCH:                t = IMM_B;
         OP_LUI, OP_AUIPC:         t = IMM_U;
         OP_JAL:                   t = IMM_J;
         default:                  t = IMM_NONE;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: selects the format from the opcode and sign-extends to XLEN.
module imm_gen
   import cpu_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
)(
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   imm_type_t   imm_type;
   logic [31:0] imm32;

   assign imm_type = imm_type_of(instr[6:0]);

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm32 = {instr[31:12], 12'b0};
         IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and decode fields, forwards the
// concurrent writeback, stalls one cycle on load-use and honours flush.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int         XLEN        = DEFAULT_XLEN,
   parameter int         REG_AW      = DEFAULT_REG_AW,
   parameter logic [6:0] LOAD_OPCODE = OP_LOAD
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [6:0]        ex_opcode,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7
);

   logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
   logic [XLEN-1:0]   in_imm;
   logic              bubble_req, capture, wb_live;

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
   logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
   logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
   logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
   logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
   logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic [6:0]        ex_opcode_q, ex_opcode_d;
   logic [2:0]        ex_funct3_q, ex_funct3_d;
   logic [6:0]        ex_funct7_q, ex_funct7_d;

   assign in_rs1 = in_instr[19:15];
   assign in_rs2 = in_instr[24:20];
   assign in_rd  = in_instr[11:7];

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr[31:0]),
      .imm   (in_imm)
   );

   // The register file only shows a write on the cycle after it, so a write
   // landing this cycle must be taken from the writeback bus instead.
   function automatic logic [XLEN-1:0] read_operand(
      input logic [REG_AW-1:0] idx,
      input logic [XLEN-1:0]   rf_val,
      input logic              live,
      input logic [REG_AW-1:0] wr_idx,
      input logic [XLEN-1:0]   wr_val
   );
      logic [XLEN-1:0] v;
      if (idx == '0)
         v = '0;
      else if (live && wr_idx == idx)
         v = wr_val;
      else
         v = rf_val;
      return v;
   endfunction

   assign wb_live    = wb_en && (wb_rd != '0);
   assign bubble_req = out_valid_q && (ex_opcode_q == LOAD_OPCODE) && (ex_rd_q != '0) &&
                       ((ex_rd_q == in_rs1) || (ex_rd_q == in_rs2));
   assign in_ready   = !bubble_req && (!out_valid_q || out_ready);
   assign capture    = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d   = out_valid_q;
      ex_pc_d       = ex_pc_q;
      ex_rs1_data_d = ex_rs1_data_q;
      ex_rs2_data_d = ex_rs2_data_q;
      ex_imm_d      = ex_imm_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rd_d       = ex_rd_q;
      ex_opcode_d   = ex_opcode_q;
      ex_funct3_d   = ex_funct3_q;
      ex_funct7_d   = ex_funct7_q;

      if (capture) begin
         out_valid_d   = 1'b1;
         ex_pc_d       = in_pc;
         ex_rs1_data_d = read_operand(in_rs1, rf_rdata1, wb_live, wb_rd, wb_data);
         ex_rs2_data_d = read_operand(in_rs2, rf_rdata2, wb_live, wb_rd, wb_data);
         ex_imm_d      = in_imm;
         ex_rs1_d      = in_rs1;
         ex_rs2_d      = in_rs2;
         ex_rd_d       = in_rd;
         ex_opcode_d   = in_instr[6:0];
         ex_funct3_d   = in_instr[14:12];
         ex_funct7_d   = in_instr[31:25];
      end else begin
         // A stalled instruction must not miss writebacks retiring underneath it.
         if (out_valid_q && !out_ready) begin
            if (wb_live && wb_rd == ex_rs1_q)
               ex_rs1_data_d = wb_data;
            if (wb_live && wb_rd == ex_rs2_q)
               ex_rs2_data_d = wb_data;
         end
         if (flush || out_ready)
            out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         ex_pc_q       <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         ex_opcode_q   <= '0;
         ex_funct3_q   <= '0;
         ex_funct7_q   <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_opcode_q   <= ex_opcode_d;
         ex_funct3_q   <= ex_funct3_d;
         ex_funct7_q   <= ex_funct7_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_rs1_data = ex_rs1_data_q;
   assign ex_rs2_data = ex_rs2_data_q;
   assign ex_imm      = ex_imm_q;
   assign ex_rs1      = ex_rs1_q;
   assign ex_rs2      = ex_rs2_q;
   assign ex_rd       = ex_rd_q;
   assign ex_opcode   = ex_opcode_q;
   assign ex_funct3   = ex_funct3_q;
   assign ex_funct7   = ex_funct7_q;

endmodule
